// File: rtl/game_sequencer.sv
// game_sequencer: spell-casting round controller (READY/PLAY/TIMES_UP/BOARD) with IR hit scoring.
// Build option GAME_SEQ_ABORT_EN adds an abort input that drops any running round back to IDLE.
module game_sequencer #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int READY_SECS = 3,
    parameter int PLAY_SECS  = 30,
    parameter int UP_SECS    = 2,
    parameter int BOARD_SECS = 10,
    parameter int SCORE_W    = 8
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start,
`ifdef GAME_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    input  logic [1:0]           house_sel,
    input  logic [24:0]          ir_in,
    output logic                 G,
    output logic                 S,
    output logic                 H,
    output logic                 R,
    output logic                 get_ready,
    output logic                 times_up,
    output logic                 leaderboard,
    output logic [7:0]           secs_left,
    output logic [SCORE_W-1:0]   score,
    output logic [4*SCORE_W-1:0] high_score
);
    localparam int TW = $clog2(TICK_DIV + 1);

    typedef enum logic [2:0] {IDLE, READY, PLAY, TIMES_UP, BOARD} state_t;

    state_t              state, state_n;
    logic [TW-1:0]       tick;
    logic [7:0]          sec, dur;
    logic [1:0]          house;
    logic [24:0]         sync1, sync2, prev, rise;
    logic [5:0]          hits;
    logic [SCORE_W+5:0]  sum;
    logic [SCORE_W-1:0]  score_n;
    logic                done, abort_req;

`ifdef GAME_SEQ_ABORT_EN
    assign abort_req = abort && state != IDLE;
`else
    assign abort_req = 1'b0;
`endif

    assign G           = state != IDLE && house == 2'd0;
    assign S           = state != IDLE && house == 2'd1;
    assign H           = state != IDLE && house == 2'd2;
    assign R           = state != IDLE && house == 2'd3;
    assign get_ready   = state == READY;
    assign times_up    = state == TIMES_UP;
    assign leaderboard = state == BOARD;
    assign secs_left   = state == IDLE ? 8'd0 : dur - sec;

    // phase length, rising-edge hit count and saturating next score
    always_comb begin
        dur = state == READY    ? 8'(READY_SECS) :
              state == PLAY     ? 8'(PLAY_SECS)  :
              state == TIMES_UP ? 8'(UP_SECS)    :
              state == BOARD    ? 8'(BOARD_SECS) : 8'd0;
        done    = state != IDLE && sec == dur - 8'd1 && tick == TW'(TICK_DIV - 1);
        rise    = sync2 & ~prev;
        hits    = 6'($countones(rise));
        sum     = (SCORE_W+6)'(score) + (SCORE_W+6)'(hits);
        score_n = sum[SCORE_W+5:SCORE_W] != '0 ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    end

    // next-state: abort beats timeout, start only honoured in IDLE
    always_comb begin
        state_n = state;
        if (abort_req)
            state_n = IDLE;
        else if (state == IDLE)
            state_n = start ? READY : IDLE;
        else if (done)
            state_n = state == READY    ? PLAY     :
                      state == PLAY     ? TIMES_UP :
                      state == TIMES_UP ? BOARD    : IDLE;
    end

    // state register
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // tick/second timer, restarted on every phase entry
    always_ff @(posedge CLOCK_50) begin
        if (reset || state_n != state || state == IDLE) begin
            tick <= '0;
            sec  <= 8'd0;
        end else if (tick == TW'(TICK_DIV - 1)) begin
            tick <= '0;
            sec  <= sec + 8'd1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // two-flop synchroniser plus previous sample for rise detection; runs in every state
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= ir_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // house latch, score accumulation and high-score update at the end of a completed PLAY
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            house      <= 2'd0;
            score      <= '0;
            high_score <= '0;
        end else begin
            if (state == IDLE && start) begin
                house <= house_sel;
                score <= '0;
            end
            if (state == PLAY)
                score <= score_n;
            if (state == PLAY && state_n == TIMES_UP && score_n > high_score[house*SCORE_W +: SCORE_W])
                high_score[house*SCORE_W +: SCORE_W] <= score_n;
        end
    end
endmodule
